// File: rtl/blink_pkg.sv
// Shared types for the blink monitor: FSM states, fault codes and the
// expected half-period derived from the blinker counter width.
package blink_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEEK,
    TRACK,
    LOCKED,
    FAULT
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_SYNC    = 2'd3
  } err_code_t;

  // A blinker with a CBITS-wide counter toggles led every 2**CBITS cycles.
  function automatic int half_of(input int cbits);
    return 1 << cbits;
  endfunction

endpackage

// File: rtl/blink_run_counter.sv
// Edge detector plus saturating run-length counter for the led line.
// While load is high the counter restarts and edges are ignored.
module blink_run_counter
  import blink_pkg::*;
#(
  parameter int CBITS = 13
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           led_in,
  input  logic           load,
  output logic           edge_hit,
  output logic [CBITS:0] len
);

  localparam logic [CBITS:0] CNT_ONE = {{CBITS{1'b0}}, 1'b1};
  localparam logic [CBITS:0] CNT_MAX = '1;

  logic           led_q;
  logic [CBITS:0] run_cnt;

  assign edge_hit = !load && (led_in != led_q);
  assign len      = run_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q   <= 1'b0;
      run_cnt <= '0;
    end else begin
      led_q <= led_in;
      // The cycle carrying the new level is the first cycle of the next run.
      if (load || edge_hit) begin
        run_cnt <= CNT_ONE;
      end else if (run_cnt != CNT_MAX) begin
        run_cnt <= run_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/blink_monitor.sv
// Receiver-side checker for a blinker's led/flg pair: measures runs, locks,
// and latches a sticky fault code. Define BLINK_MONITOR_SVA_EN for assertions.
module blink_monitor
  import blink_pkg::*;
#(
  parameter int CBITS     = 13,
  parameter int LOCK_RUNS = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           led_in,
  input  logic           flg_in,
  output logic           edge_o,
  output logic           run_vld,
  output logic [CBITS:0] run_len,
  output logic           locked,
  output logic           err,
  output logic [1:0]     err_code
);

  localparam int             HALF_I   = half_of(CBITS);
  localparam logic [CBITS:0] HALF     = HALF_I[CBITS:0];
  localparam logic [3:0]     LOCK_TGT = LOCK_RUNS[3:0];

  state_t         state_reg;
  logic [3:0]     good_reg;
  logic [3:0]     good_inc;
  logic           flg_q;
  logic           edge_hit;
  logic [CBITS:0] len;
  logic           len_ok;
  logic           len_bad;
  logic           timeout;
  logic           sync_bad;

  blink_run_counter #(
    .CBITS(CBITS)
  ) u_run_counter (
    .clk     (clk),
    .rst     (rst),
    .led_in  (led_in),
    .load    (state_reg == IDLE),
    .edge_hit(edge_hit),
    .len     (len)
  );

  assign good_inc = good_reg + 4'd1;
  assign len_ok   = (len == HALF);
  assign len_bad  = edge_hit && !len_ok;
  // A run that reaches HALF without ending is already one cycle too long.
  assign timeout  = !edge_hit && (len == HALF);
  assign sync_bad = (edge_hit && !flg_q) || (flg_q && !edge_hit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      good_reg  <= '0;
      flg_q     <= 1'b0;
      edge_o    <= 1'b0;
      run_vld   <= 1'b0;
      run_len   <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      flg_q   <= flg_in;
      edge_o  <= edge_hit;
      run_vld <= edge_hit && (state_reg != FAULT);
      if (edge_hit && (state_reg != FAULT)) begin
        run_len <= len;
      end

      case (state_reg)
        IDLE: begin
          state_reg <= SEEK;
        end
        SEEK: begin
          // The run in progress at reset is partial and never judged.
          if (edge_hit) begin
            state_reg <= TRACK;
            good_reg  <= '0;
          end
        end
        TRACK: begin
          if (edge_hit) begin
            if (len_ok) begin
              good_reg <= good_inc;
              if (good_inc == LOCK_TGT) begin
                state_reg <= LOCKED;
                locked    <= 1'b1;
              end
            end else begin
              good_reg <= '0;
            end
          end else if (timeout) begin
            state_reg <= SEEK;
          end
        end
        LOCKED: begin
          if (sync_bad || len_bad || timeout) begin
            state_reg <= FAULT;
            locked    <= 1'b0;
            err       <= 1'b1;
            if (sync_bad) begin
              err_code <= ERR_SYNC;
            end else if (len_bad) begin
              err_code <= ERR_LEN;
            end else begin
              err_code <= ERR_TIMEOUT;
            end
          end
        end
        FAULT: begin
          state_reg <= FAULT;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

`ifdef BLINK_MONITOR_SVA_EN
  a_lock_no_err: assert property (@(posedge clk) disable iff (rst) locked |-> !err);
  a_err_sticky:  assert property (@(posedge clk) disable iff (rst) err |=> err);
  a_len_nonzero: assert property (@(posedge clk) disable iff (rst) run_vld |-> (run_len != '0));
  a_live_edges:  assert property (@(posedge clk) disable iff (rst) !err |-> s_eventually edge_o);
`else
  // Assertion-free build: behaviour is identical.
`endif

endmodule

// File: tb/tb_blink_monitor.sv
// Self-checking bench for blink_monitor with CBITS=3 (HALF=8), LOCK_RUNS=2:
// table of run sequences plus hand-written timing sequences, scoreboarded runs.
`timescale 1ns/1ps
module tb_blink_monitor;

  localparam int CBITS     = 3;
  localparam int LOCK_RUNS = 2;
  localparam int SAT       = 15;
  localparam int NV        = 10;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           led_in = 1'b0;
  logic           flg_in = 1'b0;
  logic           edge_o;
  logic           run_vld;
  logic [CBITS:0] run_len;
  logic           locked;
  logic           err;
  logic [1:0]     err_code;

  blink_monitor #(
    .CBITS    (CBITS),
    .LOCK_RUNS(LOCK_RUNS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .led_in  (led_in),
    .flg_in  (flg_in),
    .edge_o  (edge_o),
    .run_vld (run_vld),
    .run_len (run_len),
    .locked  (locked),
    .err     (err),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic vld;
    int   len;
  } sb_t;

  typedef struct {
    int n;
    int pmod_run;
    int pmod_pos;
    int fault_run;
    int exp_locked;
    int exp_err;
    int exp_code;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vecs[NV];
  int   lens[NV][8];
  int   total = 0;
  int   bad = 0;
  logic cur_led = 1'b0;
  logic vld_exp = 1'b1;
  int   hold = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // One clock: drive levels, then compare the registered outputs #1 later.
  task automatic tick(input logic led, input logic flg);
    sb_t e;
    if (led != cur_led) begin
      e.vld = vld_exp;
      e.len = (hold > SAT) ? SAT : hold;
      sb_q.push_back(e);
      hold    = 0;
      cur_led = led;
    end
    led_in = led;
    flg_in = flg;
    @(posedge clk);
    #1;
    hold++;
    if (edge_o) begin
      if (sb_q.size() == 0) begin
        check("edge_o_unexpected", int'(edge_o), 0);
      end else begin
        e = sb_q.pop_front();
        check("run_vld", int'(run_vld), int'(e.vld));
        if (e.vld) check("run_len", int'(run_len), e.len);
      end
    end else begin
      if (sb_q.size() != 0) begin
        void'(sb_q.pop_front());
        check("edge_o_missing", int'(edge_o), 1);
      end
      check("run_vld_no_edge", int'(run_vld), 0);
    end
  endtask

  // A run of len cycles, optionally starting with a led toggle; flg on tick ppos.
  task automatic seg(input bit toggle, input int len, input int ppos);
    for (int i = 0; i < len; i++) begin
      tick((toggle && i == 0) ? ~cur_led : cur_led, (i == ppos));
    end
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    flg_in = 1'b0;
    led_in = cur_led;
    @(posedge clk);
    #1;
    check("rst_edge_o", int'(edge_o), 0);
    check("rst_run_vld", int'(run_vld), 0);
    check("rst_run_len", int'(run_len), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_err", int'(err), 0);
    check("rst_err_code", int'(err_code), 0);
    rst     = 1'b0;
    hold    = 0;
    vld_exp = 1'b1;
    sb_q.delete();
  endtask

  initial begin
    // {n runs, pulse-override run, pulse-override pos, first run with no run_vld,
    //  locked, err, err_code}; run 0 is the partial run after reset.
    lens[0] = '{5, 8, 8, 8, 3, 0, 0, 0};  vecs[0] = '{5, -1, 0, 99, 1, 0, 0};  // ideal lock
    lens[1] = '{5, 8, 8, 7, 8, 2, 0, 0};  vecs[1] = '{6, -1, 0, 5, 0, 1, 1};   // short run
    lens[2] = '{5, 8, 8, 9, 4, 0, 0, 0};  vecs[2] = '{5, -1, 0, 4, 0, 1, 2};   // timeout
    lens[3] = '{5, 8, 8, 8, 8, 2, 0, 0};  vecs[3] = '{6, 3, -1, 5, 0, 1, 3};   // missing flg
    lens[4] = '{5, 8, 8, 7, 8, 2, 0, 0};  vecs[4] = '{6, 3, -1, 5, 0, 1, 3};   // sync beats length
    lens[5] = '{5, 8, 8, 8, 8, 2, 0, 0};  vecs[5] = '{6, 3, 3, 4, 0, 1, 3};    // stray flg
    lens[6] = '{5, 8, 6, 8, 8, 3, 0, 0};  vecs[6] = '{6, -1, 0, 99, 1, 0, 0};  // bad run then relock
    lens[7] = '{5, 8, 6, 8, 3, 0, 0, 0};  vecs[7] = '{5, -1, 0, 99, 0, 0, 0};  // one good run not enough
    lens[8] = '{5, 8, 9, 8, 8, 8, 2, 0};  vecs[8] = '{7, -1, 0, 99, 1, 0, 0};  // TRACK timeout reseeks
    lens[9] = '{20, 8, 8, 8, 3, 0, 0, 0}; vecs[9] = '{5, -1, 0, 99, 1, 0, 0};  // saturated partial run

    for (int v = 0; v < NV; v++) begin
      do_reset();
      for (int r = 0; r < vecs[v].n; r++) begin
        int pp;
        vld_exp = (r < vecs[v].fault_run);
        pp = (r == vecs[v].pmod_run) ? vecs[v].pmod_pos : lens[v][r] - 1;
        seg(r != 0, lens[v][r], pp);
      end
      check($sformatf("v%0d_locked", v), int'(locked), vecs[v].exp_locked);
      check($sformatf("v%0d_err", v), int'(err), vecs[v].exp_err);
      check($sformatf("v%0d_err_code", v), int'(err_code), vecs[v].exp_code);
      $display("vector %0d: locked=%0d err=%0d err_code=%0d", v, locked, err, err_code);
    end

    // Lock appears exactly one cycle after the third edge.
    do_reset();
    seg(0, 5, 4);
    seg(1, 8, 7);
    seg(1, 8, 7);
    check("h_locked_before_3rd_edge", int'(locked), 0);
    seg(1, 1, -1);
    check("h_locked_after_3rd_edge", int'(locked), 1);
    seg(0, 7, 6);

    // 7-cycle locked run faults on the edge that ends it.
    seg(1, 7, 6);
    check("h_short_pre_locked", int'(locked), 1);
    check("h_short_pre_err", int'(err), 0);
    seg(1, 1, -1);
    check("h_short_err", int'(err), 1);
    check("h_short_code", int'(err_code), 1);
    check("h_short_locked", int'(locked), 0);
    vld_exp = 1'b0;
    seg(0, 3, -1);
    seg(1, 2, -1);
    check("h_fault_sticky_err", int'(err), 1);
    check("h_fault_sticky_code", int'(err_code), 1);
    $display("sequence short-run: err=%0d err_code=%0d", err, err_code);

    // One-cycle reset from FAULT, then relock on the ideal stream.
    do_reset();
    seg(0, 5, 4);
    seg(1, 8, 7);
    seg(1, 8, 7);
    seg(1, 8, 7);
    seg(1, 3, -1);
    check("h_relock_locked", int'(locked), 1);
    check("h_relock_err", int'(err), 0);
    $display("sequence relock: locked=%0d err=%0d", locked, err);

    // Timeout fires only after the 9th stable cycle.
    seg(0, 5, -1);
    check("h_no_timeout_at_8", int'(err), 0);
    seg(0, 1, -1);
    check("h_timeout_err", int'(err), 1);
    check("h_timeout_code", int'(err_code), 2);
    check("h_timeout_locked", int'(locked), 0);
    $display("sequence timeout: err=%0d err_code=%0d", err, err_code);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
